// File: rtl/fip_32_div_seq.sv
// -----------------------------------------------------------------------------
// fip_32_div_seq
//   Iterative signed fixed-point divider, z = x / y, for 32-bit
//   Q(32-FRA_BITS).FRA_BITS operands. It uses a restoring shift-subtract core
//   and produces one quotient bit per CALC cycle. With FIP_DIV_RADIX4_EN
//   defined it produces two bits per cycle through two cascaded
//   compare-subtract stages. Results are bit-identical in both builds.
//
//   Handshake: an operand pair transfers on an edge where i_valid=1 and
//   o_ready=1. o_ready is high only in IDLE. A result transfers on an edge
//   where o_valid=1 and i_ready=1. o_valid is high only in DONE, and
//   o_z/o_ovf/o_dbz are held stable until that edge. Input activity outside
//   IDLE is ignored.
//
//   Parameters
//     FRA_BITS  fractional bits (even, 2..30)
//     SAT       1 = saturate on overflow, 0 = wrap to the low 32 bits
//   Optional macro
//     FIP_DIV_RADIX4_EN  retire 2 quotient bits per CALC cycle
//
//   Ports
//     i_clk, i_rst     clock, synchronous active-high reset
//     i_valid/o_ready  operand handshake; i_x dividend, i_y divisor
//     o_valid/i_ready  result handshake; o_z quotient
//     o_ovf            quotient exceeded the 32-bit range
//     o_dbz            divide by zero
//     o_dbg_state      FSM state (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module fip_32_div_seq #(
    parameter int FRA_BITS = 16,
    parameter int SAT      = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_z,
    output logic        o_ovf,
    output logic        o_dbz,
    output logic [1:0]  o_dbg_state
);

    localparam int QB = 32 + FRA_BITS;   // quotient bits to produce
`ifdef FIP_DIV_RADIX4_EN
    localparam int STEPS = QB / 2;
`else
    localparam int STEPS = QB;
`endif
    localparam int CW = 7;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic           r_sign;
    logic [31:0]    r_ay;
    logic [31:0]    r_rem;
    // Dividend shifts out of the MSB while quotient bits shift into the LSB.
    // After STEPS cycles the register holds the full QB-bit quotient.
    logic [QB-1:0]  r_dvd;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_z;
    logic           r_ovf;
    logic           r_dbz;

    logic [31:0]    w_ax;
    logic [31:0]    w_ay;
    logic [32:0]    w_rem_sh1;
    logic           w_ge1;
    logic [31:0]    w_rem1;
`ifdef FIP_DIV_RADIX4_EN
    logic [32:0]    w_rem_sh2;
    logic           w_ge2;
    logic [31:0]    w_rem2;
`endif
    logic [31:0]    w_rem_nx;
    logic [QB-1:0]  w_dvd_nx;
    logic           w_hi_nz;
    logic           w_ovf;
    logic [31:0]    w_mag;
    logic [31:0]    w_signed;
    logic [31:0]    w_z_res;

    // Magnitudes as unsigned. FIP_MIN maps to 2^31, which still fits in 32 bits.
    assign w_ax = i_x[31] ? (~i_x + 32'd1) : i_x;
    assign w_ay = i_y[31] ? (~i_y + 32'd1) : i_y;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_nx = r_state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_state_nx = (i_y == 32'd0) ? S_DONE : S_CALC;
            end
            S_CALC: if (r_cnt == CW'(1)) w_state_nx = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign o_dbg_state = r_state;

    // Compare-subtract step(s). The remainder is always below |y| <= 2^31,
    // so after subtraction it fits back into 32 bits.
    always_comb begin
        w_rem_sh1 = {r_rem, r_dvd[QB-1]};
        w_ge1     = (w_rem_sh1 >= {1'b0, r_ay});
        w_rem1    = 32'(w_ge1 ? (w_rem_sh1 - {1'b0, r_ay}) : w_rem_sh1);
`ifdef FIP_DIV_RADIX4_EN
        w_rem_sh2 = {w_rem1, r_dvd[QB-2]};
        w_ge2     = (w_rem_sh2 >= {1'b0, r_ay});
        w_rem2    = 32'(w_ge2 ? (w_rem_sh2 - {1'b0, r_ay}) : w_rem_sh2);
        w_rem_nx  = w_rem2;
        w_dvd_nx  = {r_dvd[QB-3:0], w_ge1, w_ge2};
`else
        w_rem_nx  = w_rem1;
        w_dvd_nx  = {r_dvd[QB-2:0], w_ge1};
`endif
    end

    // Result formation from the final quotient (valid on the last CALC cycle).
    // A zero magnitude negates to zero, so a zero dividend always yields +0.
    always_comb begin
        w_mag    = w_dvd_nx[31:0];
        w_hi_nz  = |w_dvd_nx[QB-1:32];
        w_signed = r_sign ? (32'd0 - w_mag) : w_mag;
        // Negative results may reach exactly 2^31 (FIP_MIN) without overflow.
        if (r_sign) w_ovf = w_hi_nz | (w_mag[31] & (|w_mag[30:0]));
        else        w_ovf = w_hi_nz | w_mag[31];
        w_z_res = w_signed;
        if (w_ovf && (SAT != 0)) w_z_res = r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign <= 1'b0;
            r_ay   <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_cnt  <= '0;
            r_z    <= '0;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_valid) begin
                    r_sign <= i_x[31] ^ i_y[31];
                    r_ay   <= w_ay;
                    r_rem  <= '0;
                    r_dvd  <= {w_ax, {FRA_BITS{1'b0}}};
                    r_cnt  <= CW'(STEPS);
                    r_ovf  <= 1'b0;
                    if (i_y == 32'd0) begin
                        r_dbz <= 1'b1;
                        r_z   <= i_x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end else begin
                        r_dbz <= 1'b0;
                        r_z   <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= w_dvd_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_z   <= w_z_res;
                        r_ovf <= w_ovf;
                    end
                end
                default: ;   // DONE: hold the result
            endcase
        end
    end

    assign o_z   = r_z;
    assign o_ovf = r_ovf;
    assign o_dbz = r_dbz;

endmodule

// File: tb/tb_fip_32_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fip_32_div_seq
//   Bench for fip_32_div_seq. Two instances share the inputs: one built with
//   SAT=1 and one with SAT=0. A directed table of operand/result records comes
//   first. Hand-written sequences follow for backpressure and mid-CALC reset.
//   The last part is randomized traffic. Its expected values come from a
//   64-bit integer-arithmetic reference model and go into a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_fip_32_div_seq;

    localparam int F = 16;
    localparam int Q = 32 + F;
`ifdef FIP_DIV_RADIX4_EN
    localparam int LAT = Q / 2 + 1;
`else
    localparam int LAT = Q + 1;
`endif

    // ---------------- clock / reset ----------------
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [31:0] i_x = '0;
    logic [31:0] i_y = '0;
    logic        o_ready, o_valid, o_ovf, o_dbz;
    logic [31:0] o_z;
    logic [1:0]  o_dbg_state;
    logic        w_ready, w_valid, w_ovf, w_dbz;
    logic [31:0] w_z;
    logic [1:0]  w_dbg_state;

    always #5 i_clk = ~i_clk;

    fip_32_div_seq #(.FRA_BITS(F), .SAT(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_x(i_x), .i_y(i_y), .o_valid(o_valid), .i_ready(i_ready),
        .o_z(o_z), .o_ovf(o_ovf), .o_dbz(o_dbz), .o_dbg_state(o_dbg_state)
    );

    fip_32_div_seq #(.FRA_BITS(F), .SAT(0)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(w_ready),
        .i_x(i_x), .i_y(i_y), .o_valid(w_valid), .i_ready(i_ready),
        .o_z(w_z), .o_ovf(w_ovf), .o_dbz(w_dbz), .o_dbg_state(w_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [65:0] exp_q[$];   // {z_sat, z_wrap, ovf, dbz}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [65:0] model(input logic [31:0] x, input logic [31:0] y);
        longint      num, q;
        logic [31:0] zs, zw;
        logic        ov, dz;
        if (y == 32'd0) begin
            dz = 1'b1;
            ov = 1'b0;
            zs = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            zw = zs;
        end else begin
            dz  = 1'b0;
            num = longint'($signed(x)) * (longint'(1) <<< F);
            q   = num / longint'($signed(y));   // truncates toward zero
            ov  = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            zw  = q[31:0];
            zs  = ov ? ((q > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : zw;
        end
        return {zs, zw, ov, dz};
    endfunction

    // ---------------- driver tasks ----------------
    // Presents operands just after an edge; the next edge is the accept edge.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        int t = 0;
        while (!o_ready && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        chk("ready_before_launch", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_x     = x;
        i_y     = y;
    endtask

    // Counts edges from the accept edge until o_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            lat++;
        end while (!o_valid && lat < 200);
    endtask

    task automatic check_result(input string name, input logic [65:0] e);
        chk({name, "_z_sat"},  64'(o_z),   64'(e[65:34]));
        chk({name, "_z_wrap"}, 64'(w_z),   64'(e[33:2]));
        chk({name, "_ovf"},    64'(o_ovf), 64'(e[1]));
        chk({name, "_ovf_w"},  64'(w_ovf), 64'(e[1]));
        chk({name, "_dbz"},    64'(o_dbz), 64'(e[0]));
        chk({name, "_dbz_w"},  64'(w_dbz), 64'(e[0]));
    endtask

    // Full operation with i_ready=1: latency, result, one-cycle valid pulse.
    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [65:0] e);
        int lat;
        i_ready = 1'b1;
        launch(x, y);
        wait_valid(lat);
        chk({name, "_latency"}, 64'(lat), (y == 32'd0) ? 64'd1 : 64'(LAT));
        chk({name, "_valid_w"}, 64'(w_valid), 64'd1);
        check_result(name, e);
        @(posedge i_clk); #1;
        chk({name, "_pulse"}, 64'(o_valid), 64'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] zs;
        logic [31:0] zw;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [65:0] e;
        logic [31:0] rx, ry;

        tbl[0]  = '{"six_by_two",  32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 1'b0, 1'b0};
        tbl[1]  = '{"m1_by_3",     32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 32'hFFFF_AAAB, 1'b0, 1'b0};
        tbl[2]  = '{"1_by_m3",     32'h0001_0000, 32'hFFFD_0000, 32'hFFFF_AAAB, 32'hFFFF_AAAB, 1'b0, 1'b0};
        tbl[3]  = '{"ovf_pos",     32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 32'hFFFE_0000, 1'b1, 1'b0};
        tbl[4]  = '{"min_by_m1",   32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
        tbl[5]  = '{"dbz_neg",     32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1};
        tbl[6]  = '{"dbz_zero",    32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[7]  = '{"zero_div",    32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[8]  = '{"min_by_1",    32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        tbl[9]  = '{"tiny_neg",    32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[10] = '{"max_by_lsb",  32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_0000, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_z",     64'(o_z),     64'd0);
        chk("rst_ovf",   64'(o_ovf),   64'd0);
        chk("rst_dbz",   64'(o_dbz),   64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Directed table
        for (int i = 0; i < 11; i++)
            run_op(tbl[i].name, tbl[i].x, tbl[i].y,
                   {tbl[i].zs, tbl[i].zw, tbl[i].ovf, tbl[i].dbz});

        // Backpressure: result held, new operands ignored
        i_ready = 1'b0;
        launch(32'h0006_0000, 32'h0002_0000);
        wait_valid(lat);
        chk("hold_latency", 64'(lat), 64'(LAT));
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            i_x     = $urandom;
            i_y     = $urandom;
            @(posedge i_clk); #1;
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_ready", 64'(o_ready), 64'd0);
            chk("hold_z",     64'(o_z),     64'h0003_0000);
            chk("hold_ovf",   64'(o_ovf),   64'd0);
            chk("hold_dbz",   64'(o_dbz),   64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("release_valid", 64'(o_valid), 64'd0);
        chk("release_ready", 64'(o_ready), 64'd1);
        run_op("after_hold", 32'hFFFF_0000, 32'h0003_0000, model(32'hFFFF_0000, 32'h0003_0000));

        // Reset at cycle 20 of CALC
        launch(32'h0006_0000, 32'h0002_0000);
        @(posedge i_clk); #1;            // accept edge, CALC cycle 1
        i_valid = 1'b0;
        repeat (19) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_z",     64'(o_z),     64'd0);
        chk("midrst_ovf",   64'(o_ovf),   64'd0);
        run_op("after_rst", 32'h0006_0000, 32'h0002_0000, model(32'h0006_0000, 32'h0002_0000));

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            rx = $urandom;
            case ($urandom_range(0, 4))
                0:       ry = $urandom;
                1:       ry = 32'($urandom_range(1, 32'h0000_FFFF));
                2:       ry = 32'd0 - 32'($urandom_range(1, 32'h0003_FFFF));
                3:       ry = 32'd0;
                default: begin
                    rx = 32'($urandom_range(0, 32'h0010_0000));
                    ry = $urandom;
                end
            endcase
            exp_q.push_back(model(rx, ry));
            launch(rx, ry);
            wait_valid(lat);
            chk("rand_latency", 64'(lat), (ry == 32'd0) ? 64'd1 : 64'(LAT));
            e = exp_q.pop_front();
            check_result("rand", e);
            @(posedge i_clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
